mem_pipe: RTL and testbench
===========================

MEM_PIPE -- requirements
Module: mem_pipe

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 4, address width; depth DEPTH = 2**ADDR_W words.
REQ-003 Parameter RD_LAT, default 1, read latency in cycles; legal range 1..4.
REQ-004 CLK  in  1  clock; all state SHALL update on rising edge.
REQ-005 RST  in  1  reset; one clock, asynchronous, active-low.
REQ-006 EN  in  1  request strobe, one request per cycle when high.
REQ-007 W_R  in  1  1 = write, 0 = read; sampled with EN.
REQ-008 Address  in  ADDR_W  word address.
REQ-009 Data_In  in  DATA_W  write data.
REQ-010 BE  in  DATA_W/8  byte enables for writes; ignored on reads.
REQ-011 CLR  in  1  start clear of the whole array (see Configuration).
REQ-012 Ready  out  1  request accepted this cycle if EN=1.
REQ-013 BUSY  out  1  clear engine active.
REQ-014 Data_Out  out  DATA_W  read data.
REQ-015 Valid_Out  out  1  Data_Out carries read data this cycle.

Function
REQ-016 Ready SHALL equal !BUSY; a request is accepted only when EN=1 and Ready=1. Requests with Ready=0 SHALL be dropped without side effect.
REQ-017 Accepted write: each byte i with BE[i]=1 SHALL be written to mem[Address] at that edge; bytes with BE[i]=0 SHALL be unchanged. A write SHALL NOT produce Valid_Out.
REQ-018 Accepted read at edge N: Valid_Out=1 and Data_Out=mem[Address] SHALL appear for exactly one cycle following edge N+RD_LAT-1 (RD_LAT=1: visible after the accepting edge).
REQ-019 Reads SHALL be fully pipelined: back-to-back reads give back-to-back Valid_Out, order preserved.
REQ-020 Read data SHALL reflect all writes accepted at earlier edges; a write accepted at edge N is visible to a read accepted at edge N+1.
REQ-021 When Valid_Out=0, Data_Out SHALL be 0.
REQ-022 Clear engine states: IDLE, CLEAR. IDLE -> CLEAR on CLR=1 while IDLE. In CLEAR, the engine SHALL write 0 to addresses 0..DEPTH-1, one per cycle, ascending, then return to IDLE; BUSY=1 for exactly DEPTH cycles.
REQ-023 CLR and EN both high in IDLE: the request SHALL be accepted and executed; CLEAR starts at the same edge and BUSY rises after it.
REQ-024 CLR while in CLEAR SHALL be ignored; the counter SHALL NOT restart.
REQ-025 Reads accepted before CLEAR SHALL complete normally through the pipeline during CLEAR, with data read before the clear reached that address.
REQ-026 Address counter SHALL stop at DEPTH-1 without wrapping into a second pass.

Reset
REQ-027 RST low SHALL asynchronously force Data_Out=0, Valid_Out=0, BUSY=0, Ready=1, clear-engine state IDLE, counter 0, and flush all in-flight reads.
REQ-028 Array contents SHALL NOT be affected by reset; they are undefined until written or cleared.
REQ-029 Reset asserted mid-CLEAR SHALL abort the clear; addresses not yet cleared keep prior contents.

Configuration
REQ-030 Macro MEM_PIPE_CLR_EN defined: clear engine present as specified in REQ-022..026.
REQ-031 MEM_PIPE_CLR_EN undefined: CLR SHALL be ignored, BUSY tied 0, Ready tied 1; no clear logic synthesised.

Verification
REQ-032 RD_LAT=1: write 0xDEADBEEF to addr 3 with BE=4'hF, read addr 3 next cycle -> Valid_Out=1, Data_Out=0xDEADBEEF one cycle after the read edge.
REQ-033 Byte enables: write 0x11223344 to addr 5 with BE=4'hF, then 0xAABBCCDD with BE=4'b0101, read addr 5 -> 0x11BB33DD.
REQ-034 RD_LAT=3: reads of addr 0,1,2 on consecutive cycles (preloaded 0xA,0xB,0xC) -> Valid_Out high for 3 consecutive cycles starting 3 edges after the first read, data 0xA,0xB,0xC.
REQ-035 With MEM_PIPE_CLR_EN, ADDR_W=4: fill all 16 words with 0xFFFFFFFF, pulse CLR with EN=1 read addr 15 -> read returns 0xFFFFFFFF; BUSY high 16 cycles; Ready=0 and EN dropped during BUSY; subsequent reads of all addresses return 0.
REQ-036 Assert RST after 5 cycles of CLEAR -> BUSY=0, Valid_Out=0 immediately; after release, addr 0..4 read 0, addr 5..15 read 0xFFFFFFFF.
REQ-037 Without MEM_PIPE_CLR_EN: pulse CLR -> BUSY stays 0, Ready stays 1, array unchanged.

Source files
------------

// File: rtl/mem_pipe.sv
// Byte-enabled single-port memory with a fully pipelined read path of RD_LAT cycles.
// Optional whole-array clear engine is built only when MEM_PIPE_CLR_EN is defined.
module mem_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  W_R,
  input  logic [ADDR_W-1:0]     Address,
  input  logic [DATA_W-1:0]     Data_In,
  input  logic [DATA_W/8-1:0]   BE,
  input  logic                  CLR,
  output logic                  Ready,
  output logic                  BUSY,
  output logic [DATA_W-1:0]     Data_Out,
  output logic                  Valid_Out
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] pipe_data_q [RD_LAT];
  logic [RD_LAT-1:0] pipe_vld_q;

  logic              busy_s;
  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              accept_s;
  logic              wr_acc_s;
  logic              rd_acc_s;

`ifdef MEM_PIPE_CLR_EN
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  clr_state_e        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;

  // Clear sequencer: one zero write per cycle, ascending, single pass; CLR ignored while clearing.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (CLR) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          if (&cnt_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy_s     = busy_q;
  assign clr_we_s   = (state_q == CLEAR);
  assign clr_addr_s = cnt_q;
`else
  logic unused_clr_s;

  assign unused_clr_s = CLR;
  assign busy_s       = 1'b0;
  assign clr_we_s     = 1'b0;
  assign clr_addr_s   = '0;
`endif

  assign Ready    = ~busy_s;
  assign BUSY     = busy_s;
  assign accept_s = EN & ~busy_s;
  assign wr_acc_s = accept_s & W_R;
  assign rd_acc_s = accept_s & ~W_R;

  // Array storage has no reset; writes are held off while RST is low so a reset aborts a clear cleanly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      if (clr_we_s) begin
        mem_q[clr_addr_s] <= '0;
      end else if (wr_acc_s) begin
        for (int b = 0; b < NB; b++) begin
          if (BE[b]) begin
            mem_q[Address][b*8 +: 8] <= Data_In[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read data is captured at the accepting edge, then delayed RD_LAT-1 more stages; idle stages carry zero.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pipe_vld_q <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        pipe_data_q[s] <= '0;
      end
    end else begin
      pipe_vld_q[0]  <= rd_acc_s;
      pipe_data_q[0] <= rd_acc_s ? mem_q[Address] : '0;
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_vld_q[s]  <= pipe_vld_q[s-1];
        pipe_data_q[s] <= pipe_data_q[s-1];
      end
    end
  end

  assign Data_Out  = pipe_data_q[RD_LAT-1];
  assign Valid_Out = pipe_vld_q[RD_LAT-1];

endmodule

// File: tb/tb_mem_pipe.sv
// Scoreboard bench for mem_pipe: one instance with RD_LAT=1 and one with RD_LAT=3 share stimulus.
module tb_mem_pipe;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        EN = 1'b0;
  logic        W_R = 1'b0;
  logic        CLR = 1'b0;
  logic [3:0]  Address = 4'd0;
  logic [31:0] Data_In = 32'd0;
  logic [3:0]  BE = 4'd0;

  logic        rdy1, busy1, vld1, rdy3, busy3, vld3;
  logic [31:0] dout1, dout3;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;
  exp_t q1[$];
  exp_t q3[$];

  mem_pipe #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .EN(EN), .W_R(W_R), .Address(Address), .Data_In(Data_In),
    .BE(BE), .CLR(CLR), .Ready(rdy1), .BUSY(busy1), .Data_Out(dout1), .Valid_Out(vld1));

  mem_pipe #(.DATA_W(32), .ADDR_W(4), .RD_LAT(3)) u_dut3 (
    .CLK(CLK), .RST(RST), .EN(EN), .W_R(W_R), .Address(Address), .Data_In(Data_In),
    .BE(BE), .CLR(CLR), .Ready(rdy3), .BUSY(busy3), .Data_Out(dout3), .Valid_Out(vld3));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor for the RD_LAT=1 instance
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      if (vld1) begin
        if (q1.size() == 0) chk("dut1_unexpected_valid", {31'd0, vld1}, 32'd0);
        else begin
          e = q1.pop_front();
          chk("dut1_data", dout1, e.d);
          chk("dut1_latency", 32'(cyc), 32'(e.due));
        end
      end else begin
        chk("dut1_zero_when_idle", dout1, 32'd0);
        if (q1.size() != 0 && q1[0].due < cyc) begin
          chk("dut1_missing_valid", {31'd0, vld1}, 32'd1);
          void'(q1.pop_front());
        end
      end
    end
  end

  // Monitor for the RD_LAT=3 instance
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      if (vld3) begin
        if (q3.size() == 0) chk("dut3_unexpected_valid", {31'd0, vld3}, 32'd0);
        else begin
          e = q3.pop_front();
          chk("dut3_data", dout3, e.d);
          chk("dut3_latency", 32'(cyc), 32'(e.due));
        end
      end else begin
        chk("dut3_zero_when_idle", dout3, 32'd0);
        if (q3.size() != 0 && q3[0].due < cyc) begin
          chk("dut3_missing_valid", {31'd0, vld3}, 32'd1);
          void'(q3.pop_front());
        end
      end
    end
  end

  // For reads, d is the hand-computed expected data; acc says the request should be accepted.
  task automatic op(input logic w, input logic [3:0] a, input logic [31:0] d,
                    input logic [3:0] be, input logic clr, input logic acc);
    EN = 1'b1; W_R = w; Address = a; Data_In = d; BE = be; CLR = clr;
    @(posedge CLK); #1;
    if (!w && acc) begin
      q1.push_back('{d, cyc});
      q3.push_back('{d, cyc + 2});
    end
    EN = 1'b0; W_R = 1'b0; CLR = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    int t;
    #12;
    chk("rst_valid1", {31'd0, vld1}, 32'd0);
    chk("rst_dout1", dout1, 32'd0);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    chk("rst_ready1", {31'd0, rdy1}, 32'd1);
    chk("rst_valid3", {31'd0, vld3}, 32'd0);
    chk("rst_ready3", {31'd0, rdy3}, 32'd1);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;

    op(1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1);
    op(1'b0, 4'd3, 32'hDEADBEEF, 4'h0, 1'b0, 1'b1);
    op(1'b1, 4'd5, 32'h11223344, 4'hF, 1'b0, 1'b1);
    op(1'b1, 4'd5, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b1);
    op(1'b0, 4'd5, 32'h11BB33DD, 4'h0, 1'b0, 1'b1);
    op(1'b1, 4'd5, 32'hFFFFFFFF, 4'b0000, 1'b0, 1'b1);
    op(1'b0, 4'd5, 32'h11BB33DD, 4'h0, 1'b0, 1'b1);
    op(1'b1, 4'd5, 32'h99000000, 4'b1000, 1'b0, 1'b1);
    op(1'b0, 4'd5, 32'h99BB33DD, 4'h0, 1'b0, 1'b1);
    op(1'b1, 4'd0, 32'h0000000A, 4'hF, 1'b0, 1'b1);
    op(1'b1, 4'd1, 32'h0000000B, 4'hF, 1'b0, 1'b1);
    op(1'b1, 4'd2, 32'h0000000C, 4'hF, 1'b0, 1'b1);
    op(1'b0, 4'd0, 32'h0000000A, 4'h0, 1'b0, 1'b1);
    op(1'b0, 4'd1, 32'h0000000B, 4'h0, 1'b0, 1'b1);
    op(1'b0, 4'd2, 32'h0000000C, 4'h0, 1'b0, 1'b1);
    op(1'b0, 4'd3, 32'hDEADBEEF, 4'h0, 1'b0, 1'b1);
    idle(4);

    // Reset with reads in flight: outputs drop at once and no stale read emerges afterwards.
    op(1'b0, 4'd1, 32'h0000000B, 4'h0, 1'b0, 1'b1);
    void'(q3.pop_back());
    @(negedge CLK); #1 RST = 1'b0; #1;
    chk("flush_valid1", {31'd0, vld1}, 32'd0);
    chk("flush_dout1", dout1, 32'd0);
    @(negedge CLK); RST = 1'b1;
    idle(5);

`ifdef MEM_PIPE_CLR_EN
    for (int i = 0; i < 16; i++) op(1'b1, i[3:0], 32'hFFFFFFFF, 4'hF, 1'b0, 1'b1);
    op(1'b0, 4'd0, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b1);
    op(1'b0, 4'd15, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      chk("busy_during_clear1", {31'd0, busy1}, 32'd1);
      chk("ready_during_clear3", {31'd0, rdy3}, 32'd0);
      if (i == 5) begin
        EN = 1'b1; W_R = 1'b0; Address = 4'd7;
      end else if (i == 10) begin
        EN = 1'b1; W_R = 1'b1; Address = 4'd0; Data_In = 32'h00001234; BE = 4'hF; CLR = 1'b1;
      end else begin
        EN = 1'b0; W_R = 1'b0; CLR = 1'b0;
      end
      @(posedge CLK); #1;
    end
    EN = 1'b0; W_R = 1'b0; CLR = 1'b0;
    @(negedge CLK);
    chk("busy_after_clear1", {31'd0, busy1}, 32'd0);
    chk("ready_after_clear1", {31'd0, rdy1}, 32'd1);
    chk("busy_after_clear3", {31'd0, busy3}, 32'd0);
    @(posedge CLK); #1;
    for (int i = 0; i < 16; i++) op(1'b0, i[3:0], 32'h00000000, 4'h0, 1'b0, 1'b1);
    idle(4);

    // Reset five cycles into a clear aborts it with addresses 0..4 cleared.
    for (int i = 0; i < 16; i++) op(1'b1, i[3:0], 32'hFFFFFFFF, 4'hF, 1'b0, 1'b1);
    CLR = 1'b1;
    @(posedge CLK); #1 CLR = 1'b0;
    repeat (5) @(posedge CLK);
    #2 RST = 1'b0; #1;
    chk("abort_busy1", {31'd0, busy1}, 32'd0);
    chk("abort_valid1", {31'd0, vld1}, 32'd0);
    chk("abort_busy3", {31'd0, busy3}, 32'd0);
    chk("abort_ready3", {31'd0, rdy3}, 32'd1);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 16; i++)
      op(1'b0, i[3:0], (i < 5) ? 32'h00000000 : 32'hFFFFFFFF, 4'h0, 1'b0, 1'b1);
`else
    op(1'b0, 4'd3, 32'hDEADBEEF, 4'h0, 1'b1, 1'b1);
    CLR = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("noclr_busy1", {31'd0, busy1}, 32'd0);
      chk("noclr_ready1", {31'd0, rdy1}, 32'd1);
      chk("noclr_busy3", {31'd0, busy3}, 32'd0);
      @(posedge CLK); #1;
    end
    CLR = 1'b0;
    op(1'b0, 4'd0, 32'h0000000A, 4'h0, 1'b0, 1'b1);
    op(1'b0, 4'd1, 32'h0000000B, 4'h0, 1'b0, 1'b1);
    op(1'b0, 4'd2, 32'h0000000C, 4'h0, 1'b0, 1'b1);
    op(1'b0, 4'd5, 32'h99BB33DD, 4'h0, 1'b0, 1'b1);
    op(1'b1, 4'd4, 32'h5A5AA5A5, 4'hF, 1'b0, 1'b1);
    op(1'b0, 4'd4, 32'h5A5AA5A5, 4'h0, 1'b0, 1'b1);
`endif

    t = 0;
    while ((q1.size() != 0 || q3.size() != 0) && t < 20) begin
      @(posedge CLK); t++;
    end
    @(negedge CLK);
    chk("scoreboard_drained", 32'(q1.size() + q3.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
